// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one shared multiplier walks the tap line once per
// accepted sample, then holds the result until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for a sample; coefficient writes and flush allowed
// ACCUM  | one coef*tap product added to acc per cycle, idx walks 0..NUM_REGS-1
// OUTPUT | acc presented on out_data until out_ready
module fir_mac_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   input  logic                        out_ready,
   input  logic                        cfg_we,
   input  logic [$clog2(NUM_REGS)-1:0] cfg_addr,
   input  logic [DATA_WIDTH-1:0]       cfg_wdata,
   input  logic                        flush,
   output logic                        cfg_err,
   output logic                        busy
);

   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   tap_q  [NUM_REGS];
   logic [DATA_WIDTH-1:0]   tap_d  [NUM_REGS];
   logic [DATA_WIDTH-1:0]   coef_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   coef_d [NUM_REGS];
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic                    cfg_err_q, cfg_err_d;
   logic                    addr_ok;
   logic [DATA_WIDTH-1:0]   prod;

   // Product kept at DATA_WIDTH: the wrap is part of the filter's arithmetic.
   assign prod    = coef_q[idx_q] * tap_q[idx_q];
   assign addr_ok = 32'(cfg_addr) < NUM_REGS;

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      coef_d    = coef_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      cfg_err_d = 1'b0;

      if (cfg_we) begin
         if (state_q == IDLE && addr_ok) coef_d[cfg_addr] = cfg_wdata;
         else                            cfg_err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (flush) begin
               for (int k = 0; k < NUM_REGS; k++) tap_d[k] = '0;
            end else if (in_valid) begin
               tap_d[0] = in_data;
               for (int k = 1; k < NUM_REGS; k++) tap_d[k] = tap_q[k-1];
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + prod;
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NUM_REGS - 1)) state_d = OUTPUT;
         end
         OUTPUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         idx_q     <= '0;
         cfg_err_q <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            tap_q[k]  <= '0;
            coef_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         cfg_err_q <= cfg_err_d;
         tap_q     <= tap_d;
         coef_q    <= coef_d;
      end
   end

   // Flush takes priority over a sample, so the sample is refused that cycle.
   assign in_ready  = (state_q == IDLE) && !flush;
   assign out_valid = (state_q == OUTPUT);
   assign out_data  = acc_q;
   assign busy      = (state_q != IDLE);
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq with four 16-bit taps; expected results
// are worked out by hand from the tap history and coefficient set.
module tb_fir_mac_seq;

   localparam int DW = 16;
   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [DW-1:0] cfg_wdata;
   logic          flush;
   logic          cfg_err;
   logic          busy;

   int total = 0;
   int bad   = 0;

   fir_mac_seq #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .flush     (flush),
      .cfg_err   (cfg_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [DW-1:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic send_sample(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits for out_valid; lat is the number of edges expected from the call.
   task automatic wait_out(input string tag, input logic [DW-1:0] exp, input int lat);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"},  32'(out_data),  32'(exp));
      check({tag, "_lat"},   32'(n),         32'(lat));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      flush     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_cfg_err",   32'(cfg_err),   32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);

      // coefs {1,2,3,4}; samples 10 then 20
      cfg_write(2'd0, 16'd1);
      cfg_write(2'd1, 16'd2);
      cfg_write(2'd2, 16'd3);
      cfg_write(2'd3, 16'd4);
      check("cfg_ok_no_err", 32'(cfg_err), 32'd0);
      send_sample(16'd10);
      check("accum_busy",     32'(busy),     32'd1);
      check("accum_in_ready", 32'(in_ready), 32'd0);
      wait_out("s10", 16'd10, 4);
      tick();
      check("s10_taken",    32'(out_valid), 32'd0);
      check("s10_idle_rdy", 32'(in_ready),  32'd1);
      send_sample(16'd20);
      wait_out("s20", 16'd40, 4);
      tick();

      // wrap: coef0=FFFF, sample 2 -> FFFE
      cfg_write(2'd0, 16'hFFFF);
      cfg_write(2'd1, 16'd0);
      cfg_write(2'd2, 16'd0);
      cfg_write(2'd3, 16'd0);
      send_sample(16'd2);
      wait_out("wrap", 16'hFFFE, 4);
      tick();

      // backpressure: taps {5,2,20,10}, result 5*FFFF -> FFFB
      out_ready = 1'b0;
      send_sample(16'd5);
      wait_out("bp", 16'hFFFB, 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data",  32'(out_data),  32'hFFFB);
         check("bp_hold_rdy",   32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_released", 32'(out_valid), 32'd0);
      check("bp_idle_rdy", 32'(in_ready),  32'd1);

      // cfg write during ACCUM rejected; taps {1,5,2,20} -> 97
      cfg_write(2'd0, 16'd1);
      cfg_write(2'd1, 16'd2);
      cfg_write(2'd2, 16'd3);
      cfg_write(2'd3, 16'd4);
      send_sample(16'd1);
      cfg_we    = 1'b1;
      cfg_addr  = 2'd1;
      cfg_wdata = 16'd9;
      tick();
      cfg_we = 1'b0;
      check("err_pulse", 32'(cfg_err), 32'd1);
      tick();
      check("err_clear", 32'(cfg_err), 32'd0);
      wait_out("err_res", 16'd97, 2);
      tick();
      // taps {0,1,5,2}: coef1 still 2 gives 25 (coef1=9 would give 32)
      send_sample(16'd0);
      wait_out("coef1_kept", 16'd25, 4);
      tick();

      // reset in second ACCUM cycle
      send_sample(16'd8);
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_data",  32'(out_data),  32'd0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      cfg_write(2'd0, 16'd1);
      send_sample(16'd7);
      wait_out("post_rst", 16'd7, 4);
      tick();

      // flush: coefs {1,1,1,1}
      cfg_write(2'd1, 16'd1);
      cfg_write(2'd2, 16'd1);
      cfg_write(2'd3, 16'd1);
      send_sample(16'd5);
      wait_out("fl_s5", 16'd12, 4);
      tick();
      send_sample(16'd6);
      wait_out("fl_s6", 16'd18, 4);
      tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd9;
      #1;
      check("flush_blocks_rdy", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_not_taken", 32'(busy), 32'd0);
      send_sample(16'd3);
      wait_out("flushed", 16'd3, 4);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
